conv_tile_scheduler: RTL and testbench



---
 rtl/conv_tile_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_conv_tile_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_tile_scheduler.sv
// Walks a 5x5-in/3x3-out convolution core over the whole IFMAP with stride 3, one tile at a time.
// Each tile reads 25 pixels, starts the core, waits for its result (or a timeout), then writes 9 outputs.
module conv_tile_scheduler #(
  parameter int IMG_W   = 11,
  parameter int IMG_H   = 11,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 31,
  parameter int DATA_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [DATA_W-1:0]     rd_data,
  output logic                  conv_start,
  output logic [25*DATA_W-1:0]  conv_in,
  input  logic [9*DATA_W-1:0]   conv_out,
  input  logic                  conv_valid,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_W-1:0]     wr_data
);

  localparam int OUT_W = IMG_W - 2;
  localparam int TX    = OUT_W / 3;
  localparam int TY    = (IMG_H - 2) / 3;
  localparam int WCW   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CAPT, S_START, S_WAIT, S_STORE, S_NEXT, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   tx_q, tx_d, ty_q, ty_d;
  logic [4:0]          k_q, k_d;
  logic [2:0]          krow_q, krow_d, kcol_q, kcol_d;
  logic [3:0]          j_q, j_d;
  logic [1:0]          jrow_q, jrow_d, jcol_q, jcol_d;
  logic [WCW-1:0]      wait_q, wait_d;
  logic                error_q, error_d;
  logic [25*DATA_W-1:0] conv_in_q;
  logic [9*DATA_W-1:0]  result_q;

  logic                cap_en;
  logic [4:0]          cap_idx;
  logic [ADDR_W-1:0]   rd_lin, wr_lin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      tx_q    <= '0;
      ty_q    <= '0;
      k_q     <= '0;
      krow_q  <= '0;
      kcol_q  <= '0;
      j_q     <= '0;
      jrow_q  <= '0;
      jcol_q  <= '0;
      wait_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      k_q     <= k_d;
      krow_q  <= krow_d;
      kcol_q  <= kcol_d;
      j_q     <= j_d;
      jrow_q  <= jrow_d;
      jcol_q  <= jcol_d;
      wait_q  <= wait_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    k_d     = k_q;
    krow_d  = krow_q;
    kcol_d  = kcol_q;
    j_d     = j_q;
    jrow_d  = jrow_q;
    jcol_d  = jcol_q;
    wait_d  = wait_q;
    error_d = error_q;
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          error_d = 1'b0;
          tx_d    = '0;
          ty_d    = '0;
          k_d     = '0;
          krow_d  = '0;
          kcol_d  = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (k_q == 5'd24) begin
          k_d     = '0;
          krow_d  = '0;
          kcol_d  = '0;
          state_d = S_CAPT;
        end else begin
          k_d = k_q + 5'd1;
          if (kcol_q == 3'd4) begin
            kcol_d = '0;
            krow_d = krow_q + 3'd1;
          end else begin
            kcol_d = kcol_q + 3'd1;
          end
        end
      end
      S_CAPT:  state_d = S_START;
      S_START: begin
        // Counting from 1 makes the abort land exactly TIMEOUT cycles after the start pulse.
        wait_d  = WCW'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (conv_valid) begin
          j_d     = '0;
          jrow_d  = '0;
          jcol_d  = '0;
          state_d = S_STORE;
        end else if (wait_q == WCW'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      S_STORE: begin
        if (j_q == 4'd8) begin
          state_d = S_NEXT;
        end else begin
          j_d = j_q + 4'd1;
          if (jcol_q == 2'd2) begin
            jcol_d = '0;
            jrow_d = jrow_q + 2'd1;
          end else begin
            jcol_d = jcol_q + 2'd1;
          end
        end
      end
      S_NEXT: begin
        if (tx_q == ADDR_W'(TX - 1)) begin
          tx_d = '0;
          if (ty_q == ADDR_W'(TY - 1)) begin
            state_d = S_DONE;
          end else begin
            ty_d    = ty_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end else begin
          tx_d    = tx_q + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read data arrives one cycle late, so each FETCH cycle stores the previous read.
  assign cap_en  = ((state_q == S_FETCH) && (k_q != 5'd0)) || (state_q == S_CAPT);
  assign cap_idx = (state_q == S_CAPT) ? 5'd24 : (k_q - 5'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conv_in_q <= '0;
      result_q  <= '0;
    end else begin
      if (cap_en) conv_in_q[cap_idx*DATA_W +: DATA_W] <= rd_data;
      if ((state_q == S_WAIT) && conv_valid) result_q <= conv_out;
    end
  end

  assign rd_lin = (ADDR_W'(3) * ty_q + ADDR_W'(krow_q)) * ADDR_W'(IMG_W)
                + ADDR_W'(3) * tx_q + ADDR_W'(kcol_q);
  assign wr_lin = (ADDR_W'(3) * ty_q + ADDR_W'(jrow_q)) * ADDR_W'(OUT_W)
                + ADDR_W'(3) * tx_q + ADDR_W'(jcol_q);

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign error      = error_q;
  assign rd_en      = (state_q == S_FETCH);
  assign rd_addr    = rd_en ? rd_lin : '0;
  assign conv_start = (state_q == S_START);
  assign conv_in    = conv_in_q;
  assign wr_en      = (state_q == S_STORE);
  assign wr_addr    = wr_en ? wr_lin : '0;
  assign wr_data    = wr_en ? result_q[j_q*DATA_W +: DATA_W] : '0;

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Bench for conv_tile_scheduler: IFMAP/OFMAP memories, a configurable core stub and an
// output-map reference computed directly from the 3x3-centre relation of each tile.
module tb_conv_tile_scheduler;

  localparam int IMG_W = 11, IMG_H = 11, ADDR_W = 8, TIMEOUT = 31, DATA_W = 8;
  localparam int OUT_W = IMG_W - 2, OUT_H = IMG_H - 2;

  logic                 clk = 1'b0, reset = 1'b1, go = 1'b0;
  logic                 busy, done, error, rd_en, conv_start, wr_en, conv_valid;
  logic [ADDR_W-1:0]    rd_addr, wr_addr;
  logic [DATA_W-1:0]    rd_data = '0, wr_data;
  logic [25*DATA_W-1:0] conv_in;
  logic [9*DATA_W-1:0]  conv_out = '0;
  logic                 stub_vld = 1'b0, spur_vld = 1'b0;

  assign conv_valid = stub_vld | spur_vld;

  conv_tile_scheduler #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W),
                        .TIMEOUT(TIMEOUT), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .go(go), .busy(busy), .done(done), .error(error),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .conv_start(conv_start),
    .conv_in(conv_in), .conv_out(conv_out), .conv_valid(conv_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

  always #5 clk = ~clk;

  logic [7:0] ifmap [0:IMG_W*IMG_H-1];
  logic [7:0] ofmap [0:OUT_W*OUT_H-1];
  int wr_cnt = 0, cyc = 0, done_cnt = 0, both_cnt = 0;
  int err_cyc = -1, done_cyc = -1;
  logic err_prev = 1'b0;
  int rd_log[$], wr_log[$], start_cyc[$];
  int lat = 8, drop_tile = -1, start_idx = 0, cd = 0;
  logic dropping = 1'b0;
  int checks = 0, errors = 0;

  int exp_rd_head [6] = '{69, 70, 71, 72, 73, 80};
  int exp_wr_t7   [9] = '{57, 58, 59, 66, 67, 68, 75, 76, 77};

  always @(posedge clk) begin
    cyc++;
    if (rd_en) begin
      rd_data <= ifmap[rd_addr];
      rd_log.push_back(int'(rd_addr));
    end
    if (wr_en) begin
      ofmap[wr_addr] <= wr_data;
      wr_log.push_back(int'(wr_addr));
      wr_cnt++;
    end
  end

  // Core stub and event monitor, both evaluated mid-cycle.
  always @(negedge clk) begin
    stub_vld = 1'b0;
    if (reset) cd = 0;
    if (cd > 0) begin
      cd--;
      if (cd == 0 && !dropping) begin
        stub_vld = 1'b1;
        for (int i = 0; i < 9; i++)
          conv_out[i*8 +: 8] = conv_in[((i/3 + 1)*5 + i%3 + 1)*8 +: 8];
      end
    end
    if (conv_start) begin
      dropping = (start_idx == drop_tile);
      start_idx++;
      cd = lat;
      start_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    if (rd_en && wr_en) both_cnt++;
    if (error && !err_prev) err_cyc = cyc;
    err_prev = error;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic prep(input int l, input int drop, input bit rnd);
    @(negedge clk);
    lat = l; drop_tile = drop; start_idx = 0;
    wr_cnt = 0; done_cnt = 0; err_cyc = -1; done_cyc = -1;
    rd_log.delete(); wr_log.delete(); start_cyc.delete();
    for (int a = 0; a < IMG_W*IMG_H; a++) ifmap[a] = rnd ? 8'($urandom_range(0, 255)) : 8'(a % 256);
    for (int a = 0; a < OUT_W*OUT_H; a++) ofmap[a] = 'x;
  endtask

  task automatic pulse_go();
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic check_ofmap(input string tag);
    for (int y = 0; y < OUT_H; y++)
      for (int x = 0; x < OUT_W; x++)
        chk(tag, ofmap[y*OUT_W + x], ifmap[(y + 1)*IMG_W + x + 1]);
  endtask

  task automatic check_full_pass(input string tag);
    @(negedge clk);
    chk({tag, "_writes"}, wr_cnt, 81);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_error"}, error, 0);
    check_ofmap({tag, "_ofmap"});
  endtask

  initial begin
    int n, wc;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_start", conv_start, 0);
    chk("rst_addr", {rd_addr, wr_addr}, 0);
    chk("rst_conv_in", conv_in === '0, 1);
    reset = 1'b0;

    // Pass 1: ramp IFMAP, 8-cycle core.
    prep(8, -1, 1'b0);
    pulse_go();
    wait_done(2000);
    check_full_pass("pass1");
    chk("pass1_reads", rd_log.size(), 225);
    for (int k = 0; k < 6; k++) chk("t7_rd_addr", rd_log[7*25 + k], exp_rd_head[k]);
    chk("t7_rd_last", rd_log[7*25 + 24], 117);
    for (int j = 0; j < 9; j++) chk("t7_wr_addr", wr_log[7*9 + j], exp_wr_t7[j]);

    // Core never answers on tile 4.
    prep(8, 4, 1'b1);
    pulse_go();
    wait_done(2000);
    chk("to_error_at_done", error, 1);
    @(negedge clk);
    chk("to_starts", start_cyc.size(), 5);
    chk("to_latency", err_cyc - start_cyc[4], TIMEOUT);
    chk("to_done_with_err", done_cyc, err_cyc);
    chk("to_writes", wr_cnt, 36);
    chk("to_idle", busy, 0);
    chk("to_sticky", error, 1);
    prep(8, -1, 1'b1);
    pulse_go();
    chk("to_err_cleared", error, 0);
    wait_done(2000);
    check_full_pass("after_to");

    // go held high for the whole pass, plus stray valid during FETCH.
    prep(8, -1, 1'b1);
    @(negedge clk); go = 1'b1;
    n = 0;
    while (!rd_en && n < 20) begin @(negedge clk); n++; end
    spur_vld = 1'b1;
    repeat (5) @(negedge clk);
    spur_vld = 1'b0;
    wait_done(2000);
    go = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold_writes", wr_cnt, 81);
    chk("hold_done_cnt", done_cnt, 1);
    chk("hold_busy", busy, 0);
    check_ofmap("hold_ofmap");

    // Reset in the middle of tile 2's STORE.
    prep(8, -1, 1'b1);
    pulse_go();
    n = 0;
    while (wr_cnt < 21 && n < 2000) begin @(negedge clk); n++; end
    chk("mid_reached_store", wr_en, 1);
    reset = 1'b1;
    wc = wr_cnt;
    @(negedge clk);
    chk("mid_busy", busy, 0);
    chk("mid_wr_en", wr_en, 0);
    chk("mid_rd_en", rd_en, 0);
    chk("mid_start", conv_start, 0);
    chk("mid_no_writes", wr_cnt, wc);
    reset = 1'b0;
    @(negedge clk);
    wr_cnt = 0; done_cnt = 0; start_idx = 0;
    pulse_go();
    chk("mid_restart_rd_en", rd_en, 1);
    chk("mid_restart_addr", rd_addr, 0);
    wait_done(2000);
    check_full_pass("mid_restart");

    // Fast and slow core.
    prep(3, -1, 1'b1);
    pulse_go();
    wait_done(2000);
    check_full_pass("lat3");
    prep(20, -1, 1'b1);
    pulse_go();
    wait_done(2000);
    check_full_pass("lat20");

    chk("rd_wr_overlap", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
